// File: rtl/exc_sched.sv
//------------------------------------------------------------------------------
// Module      : exc_sched
// Description : Exception/interrupt/ERET commit scheduler. Prioritises the
//               mem-stage cause, pulses the CP0 commit, flushes, then holds a
//               redirect until fetch accepts it. Optional macro
//               EXC_HWINT_SYNC_EN adds a 2-flop synchronizer on ext_int.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exc_sched #(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_delayslot,
    input  logic [6:0]  mem_exc,
    input  logic        mem_is_eret,
    input  logic [31:0] mem_pc_badva,
    input  logic [31:0] mem_ls_badva,
    input  logic [5:0]  ext_int,
    input  logic        timer_interrupt,
    input  logic        cp0_status_ie,
    input  logic        cp0_status_exl,
    input  logic [7:0]  cp0_status_im,
    input  logic [1:0]  cp0_cause_ip_sw,
    input  logic [31:0] cp0_epc,
    input  logic        redirect_ready,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        exc_delayslot,
    output logic [31:0] exc_badvaddr,
    output logic        exc_eret,
    output logic        flush,
    output logic        stall_req,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_flush    = 2'd1;
    localparam logic [1:0] c_redirect = 2'd2;
    localparam logic [3:0] c_cnt_init = 4'(FLUSH_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_target;
    logic [5:0]  w_ext_int_s;
    logic [7:0]  w_ip;
    logic        w_int_take;
    logic        w_exc_any;
    logic        w_take_exc;
    logic        w_take_eret;
    logic        w_take;
    logic [4:0]  w_code;
    logic [31:0] w_badva;

`ifdef EXC_HWINT_SYNC_EN
    logic [5:0] r_int_meta;
    logic [5:0] r_int_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_int_meta <= 6'd0;
            r_int_sync <= 6'd0;
        end else begin
            r_int_meta <= ext_int;
            r_int_sync <= r_int_meta;
        end
    end

    assign w_ext_int_s = r_int_sync;
`else
    assign w_ext_int_s = ext_int;
`endif

    assign w_ip        = {w_ext_int_s[5] | timer_interrupt, w_ext_int_s[4:0], cp0_cause_ip_sw};
    assign w_int_take  = mem_valid & cp0_status_ie & ~cp0_status_exl & (|(w_ip & cp0_status_im));
    assign w_exc_any   = mem_valid & (|mem_exc);
    assign w_take_exc  = w_int_take | w_exc_any;
    assign w_take_eret = mem_valid & mem_is_eret & ~w_take_exc;
    assign w_take      = (r_state == c_idle) & (w_take_exc | w_take_eret);

    // mem_exc = {adel_if, ri, ov, sys, bp, adel_ld, ades}; interrupt outranks all
    always_comb begin
        w_code  = 5'h00;
        w_badva = 32'd0;
        if (w_int_take) begin
            w_code = 5'h00;
        end else if (mem_exc[6]) begin
            w_code  = 5'h04;
            w_badva = mem_pc_badva;
        end else if (mem_exc[5]) begin
            w_code = 5'h0A;
        end else if (mem_exc[4]) begin
            w_code = 5'h0C;
        end else if (mem_exc[3]) begin
            w_code = 5'h08;
        end else if (mem_exc[2]) begin
            w_code = 5'h09;
        end else if (mem_exc[1]) begin
            w_code  = 5'h04;
            w_badva = mem_ls_badva;
        end else if (mem_exc[0]) begin
            w_code  = 5'h05;
            w_badva = mem_ls_badva;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:     if (w_take) w_next_state = c_flush;
            c_flush:    if (r_cnt == 4'd0) w_next_state = c_redirect;
            c_redirect: if (redirect_ready) w_next_state = c_idle;
            default:    w_next_state = c_idle;
        endcase
    end

    // Flush counter and redirect target, both captured in the take cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= 4'd0;
            r_target <= 32'd0;
        end else if (w_take) begin
            r_cnt    <= c_cnt_init;
            r_target <= w_take_exc ? EXC_VECTOR : cp0_epc;
        end else if (r_state == c_flush && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Outputs are forced low for as long as reset is held
    always_comb begin
        exc_valid      = 1'b0;
        exc_code       = 5'd0;
        exc_pc         = 32'd0;
        exc_delayslot  = 1'b0;
        exc_badvaddr   = 32'd0;
        exc_eret       = 1'b0;
        flush          = 1'b0;
        stall_req      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if (rst) begin
            case (r_state)
                c_idle: begin
                    if (w_take_exc) begin
                        exc_valid     = 1'b1;
                        exc_code      = w_code;
                        exc_pc        = mem_pc;
                        exc_delayslot = mem_delayslot;
                        exc_badvaddr  = w_badva;
                    end
                    exc_eret = w_take_eret;
                    flush    = w_take;
                end
                c_flush: begin
                    flush     = 1'b1;
                    stall_req = 1'b1;
                end
                c_redirect: begin
                    stall_req      = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = r_target;
                end
                default: begin
                    flush = 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exc_sched.sv
// Directed self-checking bench for exc_sched (default build, FLUSH_CYCLES=2).
`default_nettype none

module tb_exc_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_delayslot;
    logic [6:0]  mem_exc;
    logic        mem_is_eret;
    logic [31:0] mem_pc_badva;
    logic [31:0] mem_ls_badva;
    logic [5:0]  ext_int;
    logic        timer_interrupt;
    logic        cp0_status_ie;
    logic        cp0_status_exl;
    logic [7:0]  cp0_status_im;
    logic [1:0]  cp0_cause_ip_sw;
    logic [31:0] cp0_epc;
    logic        redirect_ready;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_delayslot;
    logic [31:0] exc_badvaddr;
    logic        exc_eret;
    logic        flush;
    logic        stall_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    exc_sched dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_delayslot(mem_delayslot),
        .mem_exc(mem_exc), .mem_is_eret(mem_is_eret),
        .mem_pc_badva(mem_pc_badva), .mem_ls_badva(mem_ls_badva),
        .ext_int(ext_int), .timer_interrupt(timer_interrupt),
        .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl),
        .cp0_status_im(cp0_status_im), .cp0_cause_ip_sw(cp0_cause_ip_sw),
        .cp0_epc(cp0_epc), .redirect_ready(redirect_ready),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_delayslot(exc_delayslot), .exc_badvaddr(exc_badvaddr),
        .exc_eret(exc_eret), .flush(flush), .stall_req(stall_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Finish the current take: wait (bounded) for the redirect, accept it, confirm IDLE
    task automatic drain();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            mem_valid = 1'b0; mem_exc = 7'd0; mem_is_eret = 1'b0; mem_delayslot = 1'b0;
            redirect_ready = 1'b1;
            #1;
            if (redirect_valid) seen = 1'b1;
        end
        chk("drain_redirect_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        redirect_ready = 1'b0;
        #1;
        chk("drain_idle", {30'd0, stall_req, redirect_valid}, 32'd0);
    endtask

    task automatic take_exc(input string tag, input logic [6:0] exc,
                            input logic [4:0] code, input logic [31:0] badva);
        @(negedge clk);
        mem_valid = 1'b1; mem_exc = exc; mem_pc = 32'h8000_0200; mem_delayslot = 1'b1;
        mem_pc_badva = 32'h1111_2220; mem_ls_badva = 32'h3333_4440;
        #1;
        chk({tag, "_valid"}, {31'd0, exc_valid}, 32'd1);
        chk({tag, "_code"}, {27'd0, exc_code}, {27'd0, code});
        chk({tag, "_badva"}, exc_badvaddr, badva);
        chk({tag, "_bd"}, {31'd0, exc_delayslot}, 32'd1);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        mem_valid = 1'b1; mem_pc = 32'd0; mem_delayslot = 1'b0; mem_exc = 7'b0010000;
        mem_is_eret = 1'b0; mem_pc_badva = 32'd0; mem_ls_badva = 32'd0;
        ext_int = 6'd0; timer_interrupt = 1'b0; cp0_status_ie = 1'b0; cp0_status_exl = 1'b0;
        cp0_status_im = 8'd0; cp0_cause_ip_sw = 2'd0; cp0_epc = 32'd0; redirect_ready = 1'b0;

        // Reset holds every output low even with a pending exception
        repeat (2) @(negedge clk);
        #1;
        chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst = 1'b1; mem_valid = 1'b0; mem_exc = 7'd0;

        // Overflow: commit, 3 flush cycles, exception-during-flush ignored, redirect
        @(negedge clk);
        mem_valid = 1'b1; mem_exc = 7'b0010000; mem_pc = 32'h8000_0100; mem_ls_badva = 32'h5555_0000;
        #1;
        chk("ov_valid", {31'd0, exc_valid}, 32'd1);
        chk("ov_code", {27'd0, exc_code}, 32'h0C);
        chk("ov_pc", exc_pc, 32'h8000_0100);
        chk("ov_badva", exc_badvaddr, 32'd0);
        chk("ov_flush_t0", {31'd0, flush}, 32'd1);
        @(negedge clk);
        mem_exc = 7'b0001000;
        #1;
        chk("ov_flush_t1", {30'd0, flush, stall_req}, 32'd3);
        chk("flush_ignore_exc", {31'd0, exc_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("ov_flush_t2", {30'd0, flush, stall_req}, 32'd3);
        chk("flush_ignore_exc2", {31'd0, exc_valid}, 32'd0);
        @(negedge clk);
        mem_valid = 1'b0; mem_exc = 7'd0;
        #1;
        chk("ov_redir_flush", {31'd0, flush}, 32'd0);
        chk("ov_redir_valid", {30'd0, redirect_valid, stall_req}, 32'd3);
        chk("ov_redir_pc", redirect_pc, 32'hBFC0_0380);
        @(negedge clk);
        redirect_ready = 1'b1;
        #1;
        chk("ov_redir_hold", {31'd0, redirect_valid}, 32'd1);

        // Back-to-back: first IDLE cycle takes ri+ades
        @(negedge clk);
        redirect_ready = 1'b0;
        mem_valid = 1'b1; mem_exc = 7'b0100001; mem_ls_badva = 32'hDEAD_BEEF;
        #1;
        chk("b2b_redir_off", {31'd0, redirect_valid}, 32'd0);
        chk("ri_ades_valid", {31'd0, exc_valid}, 32'd1);
        chk("ri_ades_code", {27'd0, exc_code}, 32'h0A);
        chk("ri_ades_badva", exc_badvaddr, 32'd0);
        drain();

        take_exc("adel_if", 7'b1000000, 5'h04, 32'h1111_2220);
        take_exc("adel_ld", 7'b0000010, 5'h04, 32'h3333_4440);
        take_exc("bp_adel_ld", 7'b0000110, 5'h09, 32'd0);
        take_exc("sys_bp", 7'b0001100, 5'h08, 32'd0);
        take_exc("ades", 7'b0000001, 5'h05, 32'h3333_4440);

        // Timer interrupt beats a pending ades
        @(negedge clk);
        cp0_status_ie = 1'b1; cp0_status_exl = 1'b0; cp0_status_im = 8'h80; timer_interrupt = 1'b1;
        mem_valid = 1'b1; mem_exc = 7'b0000001; mem_ls_badva = 32'hDEAD_0000; mem_pc = 32'h8000_0300;
        #1;
        chk("int_valid", {31'd0, exc_valid}, 32'd1);
        chk("int_code", {27'd0, exc_code}, 32'h00);
        chk("int_badva", exc_badvaddr, 32'd0);
        chk("int_pc", exc_pc, 32'h8000_0300);
        drain();

        // Same with EXL=1: interrupt masked, ades taken
        @(negedge clk);
        cp0_status_exl = 1'b1;
        mem_valid = 1'b1; mem_exc = 7'b0000001; mem_ls_badva = 32'hDEAD_0000;
        #1;
        chk("exl_valid", {31'd0, exc_valid}, 32'd1);
        chk("exl_code", {27'd0, exc_code}, 32'h05);
        chk("exl_badva", exc_badvaddr, 32'hDEAD_0000);
        drain();

        // Hardware line 0 maps to IP2: masked by IM, then enabled
        @(negedge clk);
        cp0_status_exl = 1'b0; timer_interrupt = 1'b0; ext_int = 6'b000001; cp0_status_im = 8'h80;
        mem_valid = 1'b1; mem_exc = 7'd0;
        #1;
        chk("hw_masked_valid", {31'd0, exc_valid}, 32'd0);
        chk("hw_masked_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        cp0_status_im = 8'h04;
        #1;
        chk("hw_int_valid", {31'd0, exc_valid}, 32'd1);
        chk("hw_int_code", {27'd0, exc_code}, 32'h00);
        drain();
        @(negedge clk);
        ext_int = 6'd0; cp0_status_ie = 1'b0; cp0_status_im = 8'd0;

        // ERET: one pulse, EPC sampled at take, redirect held until ready
        @(negedge clk);
        cp0_epc = 32'hBFC0_1234; mem_valid = 1'b1; mem_is_eret = 1'b1;
        #1;
        chk("eret_pulse", {31'd0, exc_eret}, 32'd1);
        chk("eret_no_exc", {31'd0, exc_valid}, 32'd0);
        chk("eret_flush", {31'd0, flush}, 32'd1);
        @(negedge clk);
        cp0_epc = 32'h0000_0000;
        #1;
        chk("eret_single", {31'd0, exc_eret}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        mem_valid = 1'b0; mem_is_eret = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("eret_hold_valid", {31'd0, redirect_valid}, 32'd1);
            chk("eret_hold_pc", redirect_pc, 32'hBFC0_1234);
            chk("eret_hold_no_pulse", {31'd0, exc_eret}, 32'd0);
            @(negedge clk);
        end
        redirect_ready = 1'b1;
        #1;
        chk("eret_accept_pc", redirect_pc, 32'hBFC0_1234);
        @(negedge clk);
        redirect_ready = 1'b0;
        #1;
        chk("eret_idle", {30'd0, redirect_valid, stall_req}, 32'd0);

        // Reset during REDIRECT abandons it
        @(negedge clk);
        mem_valid = 1'b1; mem_exc = 7'b0010000;
        @(negedge clk);
        mem_valid = 1'b0; mem_exc = 7'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_redirect", {31'd0, redirect_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'd0);
        chk("rst_redir_stall_flush", {30'd0, stall_req, flush}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", {28'd0, redirect_valid, stall_req, flush, exc_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
